// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and the message-type to data-length decode.
package midi_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [7:0] CHAN_STATUS_MIN = 8'h80;
   localparam logic [7:0] CHAN_STATUS_MAX = 8'hEF;
   localparam logic [7:0] SYSEX_START     = 8'hF0;
   localparam logic [7:0] SYSEX_END       = 8'hF7;
   localparam logic [7:0] REALTIME_MIN    = 8'hF8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2,
      SYSEX   = 2'd3
   } midi_state_e;

   // Number of data bytes following a channel status byte; 0 for non-channel types.
   function automatic logic [1:0] msg_data_len(input logic [3:0] msg_type);
      case (msg_type)
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 2'd2;
         4'hC, 4'hD:                   return 2'd1;
         default:                      return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel messages from a UART byte stream, with running status,
// real-time byte transparency, SysEx skipping and a count of orphaned data bytes.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter bit         OMNI    = 1'b1,
   parameter logic [3:0] CHANNEL = 4'd0
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] byte_in,
   input  logic       byte_valid_in,
   output logic [3:0] status,
   output logic [3:0] channel,
   output logic [7:0] data_byte1,
   output logic [7:0] data_byte2,
   output logic       valid_out,
   output logic [7:0] drop_count
);

   midi_state_e          r_state;
   logic [BYTE_W-1:0]    r_rs;
   logic [BYTE_W-1:0]    r_d1;

   logic       w_is_realtime;
   logic       w_is_chan_status;
   logic       w_is_sys_common;
   logic       w_is_data;
   logic [1:0] w_len;
   logic       w_accept;

   assign w_is_realtime    = (byte_in >= REALTIME_MIN);
   assign w_is_chan_status = (byte_in >= CHAN_STATUS_MIN) && (byte_in <= CHAN_STATUS_MAX);
   assign w_is_sys_common  = (byte_in >= SYSEX_START) && (byte_in <= SYSEX_END);
   assign w_is_data        = ~byte_in[7];
   assign w_len            = msg_data_len(r_rs[7:4]);
   assign w_accept         = OMNI || (r_rs[3:0] == CHANNEL);

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state    <= IDLE;
         r_rs       <= '0;
         r_d1       <= '0;
         status     <= '0;
         channel    <= '0;
         data_byte1 <= '0;
         data_byte2 <= '0;
         valid_out  <= 1'b0;
         drop_count <= '0;
      end else begin
         valid_out <= 1'b0;
         if (byte_valid_in && !w_is_realtime) begin
            if (w_is_chan_status) begin
               r_rs    <= byte_in;
               r_state <= WAIT_D1;
            end else if (byte_in == SYSEX_START) begin
               r_rs    <= '0;
               r_state <= SYSEX;
            end else if (w_is_sys_common) begin
               // Any other system-common byte (including EOX) ends the message context.
               r_rs    <= '0;
               r_state <= IDLE;
            end else if (w_is_data) begin
               case (r_state)
                  IDLE: begin
                     if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
                  end
                  WAIT_D1: begin
                     if (w_len == 2'd2) begin
                        r_d1    <= byte_in;
                        r_state <= WAIT_D2;
                     end else if (w_accept) begin
                        status     <= r_rs[7:4];
                        channel    <= r_rs[3:0];
                        data_byte1 <= byte_in;
                        data_byte2 <= '0;
                        valid_out  <= 1'b1;
                     end
                  end
                  WAIT_D2: begin
                     r_state <= WAIT_D1;
                     if (w_accept) begin
                        status     <= r_rs[7:4];
                        channel    <= r_rs[3:0];
                        data_byte1 <= r_d1;
                        data_byte2 <= byte_in;
                        valid_out  <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench: an OMNI parser and a channel-0-only parser share one byte stream.
`timescale 1ns/1ps
module tb_midi_msg_parser;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [7:0] byte_in;
   logic       byte_valid_in;

   logic [3:0] a_status, a_channel, b_status, b_channel;
   logic [7:0] a_d1, a_d2, a_drop, b_d1, b_d2, b_drop;
   logic       a_valid, b_valid;

   int n_checks = 0;
   int n_errors = 0;
   int a_pulses = 0;
   int b_pulses = 0;

   always #5 clk_in = ~clk_in;

   midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) u_omni (
      .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
      .status(a_status), .channel(a_channel), .data_byte1(a_d1), .data_byte2(a_d2),
      .valid_out(a_valid), .drop_count(a_drop)
   );

   midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd0)) u_ch0 (
      .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
      .status(b_status), .channel(b_channel), .data_byte1(b_d1), .data_byte2(b_d2),
      .valid_out(b_valid), .drop_count(b_drop)
   );

   // One strobed byte; valid_out for that byte is sampled at the following negedge.
   task automatic send_byte(input logic [7:0] b);
      byte_in       = b;
      byte_valid_in = 1'b1;
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      if (a_valid === 1'b1) a_pulses++;
      if (b_valid === 1'b1) b_pulses++;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      a_pulses = 0;
      b_pulses = 0;
   endtask

   task automatic test_reset();
      byte_valid_in = 1'b0;
      byte_in       = 8'h00;
      @(negedge clk_in);
      do_reset();
      n_checks++; if (a_status !== 4'h0)  begin n_errors++; $display("FAIL reset_status got %h exp 0", a_status); end
      n_checks++; if (a_channel !== 4'h0) begin n_errors++; $display("FAIL reset_channel got %h exp 0", a_channel); end
      n_checks++; if (a_d1 !== 8'h00)     begin n_errors++; $display("FAIL reset_d1 got %h exp 00", a_d1); end
      n_checks++; if (a_d2 !== 8'h00)     begin n_errors++; $display("FAIL reset_d2 got %h exp 00", a_d2); end
      n_checks++; if (a_valid !== 1'b0)   begin n_errors++; $display("FAIL reset_valid got %b exp 0", a_valid); end
      n_checks++; if (a_drop !== 8'h00)   begin n_errors++; $display("FAIL reset_drop got %h exp 00", a_drop); end
   endtask

   task automatic test_note_on();
      do_reset();
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
      n_checks++; if (a_pulses !== 1)   begin n_errors++; $display("FAIL note_pulses got %0d exp 1", a_pulses); end
      n_checks++; if (a_status !== 4'h9) begin n_errors++; $display("FAIL note_status got %h exp 9", a_status); end
      n_checks++; if (a_channel !== 4'h0) begin n_errors++; $display("FAIL note_channel got %h exp 0", a_channel); end
      n_checks++; if (a_d1 !== 8'h3C)   begin n_errors++; $display("FAIL note_d1 got %h exp 3c", a_d1); end
      n_checks++; if (a_d2 !== 8'h64)   begin n_errors++; $display("FAIL note_d2 got %h exp 64", a_d2); end
      n_checks++; if (b_pulses !== 1)   begin n_errors++; $display("FAIL note_ch0_pulses got %0d exp 1", b_pulses); end
      // Pulse is one cycle wide and outputs hold afterwards
      @(negedge clk_in); @(negedge clk_in);
      n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL note_pulse_width got %b exp 0", a_valid); end
      n_checks++; if (a_d2 !== 8'h64)   begin n_errors++; $display("FAIL note_hold_d2 got %h exp 64", a_d2); end
   endtask

   task automatic test_running_status();
      do_reset();
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64); send_byte(8'h40); send_byte(8'h00);
      n_checks++; if (a_pulses !== 2)   begin n_errors++; $display("FAIL rs_pulses got %0d exp 2", a_pulses); end
      n_checks++; if (a_status !== 4'h9) begin n_errors++; $display("FAIL rs_status got %h exp 9", a_status); end
      n_checks++; if (a_d1 !== 8'h40)   begin n_errors++; $display("FAIL rs_d1 got %h exp 40", a_d1); end
      n_checks++; if (a_d2 !== 8'h00)   begin n_errors++; $display("FAIL rs_d2 got %h exp 00", a_d2); end
   endtask

   task automatic test_realtime();
      do_reset();
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8);
      n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL rt_no_pulse got %b exp 0", a_valid); end
      send_byte(8'h64);
      n_checks++; if (a_pulses !== 1)   begin n_errors++; $display("FAIL rt_pulses got %0d exp 1", a_pulses); end
      n_checks++; if (a_d1 !== 8'h3C)   begin n_errors++; $display("FAIL rt_d1 got %h exp 3c", a_d1); end
      n_checks++; if (a_d2 !== 8'h64)   begin n_errors++; $display("FAIL rt_d2 got %h exp 64", a_d2); end
   endtask

   task automatic test_one_byte_filter();
      do_reset();
      send_byte(8'hC5); send_byte(8'h07);
      n_checks++; if (a_pulses !== 1)    begin n_errors++; $display("FAIL pc_pulses got %0d exp 1", a_pulses); end
      n_checks++; if (a_status !== 4'hC) begin n_errors++; $display("FAIL pc_status got %h exp c", a_status); end
      n_checks++; if (a_channel !== 4'h5) begin n_errors++; $display("FAIL pc_channel got %h exp 5", a_channel); end
      n_checks++; if (a_d1 !== 8'h07)    begin n_errors++; $display("FAIL pc_d1 got %h exp 07", a_d1); end
      n_checks++; if (a_d2 !== 8'h00)    begin n_errors++; $display("FAIL pc_d2 got %h exp 00", a_d2); end
      n_checks++; if (b_pulses !== 0)    begin n_errors++; $display("FAIL pc_filtered_pulses got %0d exp 0", b_pulses); end
      n_checks++; if (b_drop !== 8'h00)  begin n_errors++; $display("FAIL pc_filtered_drop got %h exp 00", b_drop); end
   endtask

   task automatic test_abandon();
      do_reset();
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'hD2); send_byte(8'h11);
      n_checks++; if (a_pulses !== 1)    begin n_errors++; $display("FAIL abandon_pulses got %0d exp 1", a_pulses); end
      n_checks++; if (a_status !== 4'hD) begin n_errors++; $display("FAIL abandon_status got %h exp d", a_status); end
      n_checks++; if (a_d1 !== 8'h11)    begin n_errors++; $display("FAIL abandon_d1 got %h exp 11", a_d1); end
      // System common byte clears running status; next data byte is dropped
      send_byte(8'hF2); send_byte(8'h22);
      n_checks++; if (a_pulses !== 1)    begin n_errors++; $display("FAIL syscom_pulses got %0d exp 1", a_pulses); end
      n_checks++; if (a_drop !== 8'h01)  begin n_errors++; $display("FAIL syscom_drop got %h exp 01", a_drop); end
   endtask

   task automatic test_sysex_and_saturation();
      do_reset();
      send_byte(8'hF0); send_byte(8'h12); send_byte(8'h34); send_byte(8'hF7); send_byte(8'h3C);
      n_checks++; if (a_pulses !== 0)   begin n_errors++; $display("FAIL sysex_pulses got %0d exp 0", a_pulses); end
      n_checks++; if (a_drop !== 8'h01) begin n_errors++; $display("FAIL sysex_drop got %h exp 01", a_drop); end
      for (int i = 0; i < 300; i++) send_byte(8'h05);
      n_checks++; if (a_drop !== 8'hFF) begin n_errors++; $display("FAIL drop_saturate got %h exp ff", a_drop); end
      n_checks++; if (a_pulses !== 0)   begin n_errors++; $display("FAIL drop_pulses got %0d exp 0", a_pulses); end
   endtask

   task automatic test_reset_mid_message();
      do_reset();
      send_byte(8'h90); send_byte(8'h3C);
      do_reset();
      send_byte(8'h64);
      n_checks++; if (a_pulses !== 0)   begin n_errors++; $display("FAIL midreset_pulses got %0d exp 0", a_pulses); end
      n_checks++; if (a_drop !== 8'h01) begin n_errors++; $display("FAIL midreset_drop got %h exp 01", a_drop); end
      n_checks++; if (a_d1 !== 8'h00)   begin n_errors++; $display("FAIL midreset_d1 got %h exp 00", a_d1); end
   endtask

   initial begin
      rst_in        = 1'b1;
      byte_in       = 8'h00;
      byte_valid_in = 1'b0;
      test_reset();
      test_note_on();
      test_running_status();
      test_realtime();
      test_one_byte_filter();
      test_abandon();
      test_sysex_and_saturation();
      test_reset_mid_message();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
